// File: rtl/trap_sequencer_pkg.sv
// Shared constants for the trap sequencer: exception codes,
// FSM state encodings and mtvec mode encodings.
package trap_sequencer_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CSR_W = (XLEN > 32) ? 32 : XLEN;

    localparam logic [3:0] NO_E      = 4'hF;
    localparam logic [3:0] EXT_IRQ_E = 4'd11;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_TRAP_COMMIT   = 3'd1,
        ST_TRAP_REDIRECT = 3'd2,
        ST_MRET_COMMIT   = 3'd3,
        ST_MRET_REDIRECT = 3'd4
    } trap_state_e;

endpackage

// File: rtl/trap_target_calc.sv
// Redirect target computation: mtvec base (direct or vectored
// for interrupts) or mepc; zero when no redirect is requested.
module trap_target_calc
    import trap_sequencer_pkg::*;
(
    input  logic [CSR_W-1:0] i_mtvec,
    input  logic [CSR_W-1:0] i_mepc,
    input  logic             i_sel_mepc,
    input  logic             i_irq,
    input  logic             i_valid,
    output logic [CSR_W-1:0] o_pc
);

    logic [CSR_W-1:0] base;
    logic             vec;
    logic             unused_bits;

    assign unused_bits = ^i_mepc[1:0];

    // Select the target; vector offset only for interrupts in vectored mode
    always_comb begin
        base = {i_mtvec[CSR_W-1:2], 2'b00};
        vec  = i_irq && (i_mtvec[1:0] == MTVEC_VECTORED);
        o_pc = '0;
        if (i_valid) begin
            if (i_sel_mepc) begin
                o_pc = {i_mepc[CSR_W-1:2], 2'b00};
            end else if (vec) begin
                o_pc = base + (CSR_W'(EXT_IRQ_E) << 2);
            end else begin
                o_pc = base;
            end
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Trap sequencer: arbitrates exceptions, interrupts and mret into one event.
// Optional feature macro: TRAP_SEQ_EXT_IRQ_EN (external interrupt support).
module trap_sequencer
    import trap_sequencer_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_en,
    input  logic [3:0]  i_exc_code_fd,
    input  logic [31:0] i_exc_pc_fd,
    input  logic [3:0]  i_exc_code_em,
    input  logic [31:0] i_exc_pc_em,
    input  logic [31:0] i_exc_addr_em,
    input  logic        i_mret_e,
    input  logic [31:0] i_pc_e,
`ifdef TRAP_SEQ_EXT_IRQ_EN
    input  logic        i_ext_irq,
`endif
    input  logic [31:0] i_mtvec,
    input  logic [31:0] i_mepc,
    input  logic [31:0] i_mie,
    output logic [3:0]  o_exception_code_f_d_ff,
    output logic [31:0] o_exception_pc_f_d_ff,
    output logic [3:0]  o_exception_code_e_m_ff,
    output logic [31:0] o_exception_pc_e_m_ff,
    output logic [31:0] o_exception_addr_e_m_ff,
    output logic        o_mret,
    output logic        o_flush_f_d,
    output logic        o_flush_d_e,
    output logic        o_flush_e_m,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic        o_busy,
    output logic        o_irq_taken
);

    trap_state_e state_q, state_d;

    logic [3:0]  fd_code_q, fd_code_d;
    logic [31:0] fd_pc_q, fd_pc_d;
    logic [3:0]  em_code_q, em_code_d;
    logic [31:0] em_pc_q, em_pc_d;
    logic [31:0] em_addr_q, em_addr_d;
    logic        irq_q, irq_d;

    logic exc_em, exc_fd, irq_pend, unused_mie;

    assign exc_em     = (i_exc_code_em != NO_E);
    assign exc_fd     = (i_exc_code_fd != NO_E);
    assign unused_mie = ^i_mie;

`ifdef TRAP_SEQ_EXT_IRQ_EN
    assign irq_pend = i_ext_irq && i_mie[11];
`else
    assign irq_pend = 1'b0;
`endif

    // State register; reset wins over the clock enable
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else if (i_clk_en) begin
            state_q <= state_d;
        end
    end

    // Next state: events are only looked at in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (exc_em || exc_fd || irq_pend) begin
                    state_d = ST_TRAP_COMMIT;
                end else if (i_mret_e) begin
                    state_d = ST_MRET_COMMIT;
                end
            end
            ST_TRAP_COMMIT:   state_d = ST_TRAP_REDIRECT;
            ST_TRAP_REDIRECT: state_d = ST_IDLE;
            ST_MRET_COMMIT:   state_d = ST_MRET_REDIRECT;
            ST_MRET_REDIRECT: state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Channel next values: latch the winner, retire codes after commit
    always_comb begin
        fd_code_d = fd_code_q;
        fd_pc_d   = fd_pc_q;
        em_code_d = em_code_q;
        em_pc_d   = em_pc_q;
        em_addr_d = em_addr_q;
        irq_d     = irq_q;
        unique case (state_q)
            ST_IDLE: begin
                if (exc_em) begin
                    em_code_d = i_exc_code_em;
                    em_pc_d   = i_exc_pc_em;
                    em_addr_d = i_exc_addr_em;
                    fd_code_d = NO_E;
                    irq_d     = 1'b0;
                end else if (exc_fd) begin
                    fd_code_d = i_exc_code_fd;
                    fd_pc_d   = i_exc_pc_fd;
                    em_code_d = NO_E;
                    irq_d     = 1'b0;
                end else if (irq_pend) begin
                    em_code_d = EXT_IRQ_E;
                    em_pc_d   = i_pc_e;
                    em_addr_d = '0;
                    fd_code_d = NO_E;
                    irq_d     = 1'b1;
                end
            end
            ST_TRAP_COMMIT: begin
                fd_code_d = NO_E;
                em_code_d = NO_E;
            end
            ST_TRAP_REDIRECT: irq_d = 1'b0;
            default: ;
        endcase
    end

    // Channel registers presented to the CSR file
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fd_code_q <= NO_E;
            fd_pc_q   <= '0;
            em_code_q <= NO_E;
            em_pc_q   <= '0;
            em_addr_q <= '0;
            irq_q     <= 1'b0;
        end else if (i_clk_en) begin
            fd_code_q <= fd_code_d;
            fd_pc_q   <= fd_pc_d;
            em_code_q <= em_code_d;
            em_pc_q   <= em_pc_d;
            em_addr_q <= em_addr_d;
            irq_q     <= irq_d;
        end
    end

    // Control outputs decoded from the registered state
    always_comb begin
        o_mret           = 1'b0;
        o_flush_f_d      = 1'b0;
        o_flush_d_e      = 1'b0;
        o_flush_e_m      = 1'b0;
        o_redirect_valid = 1'b0;
        o_busy           = (state_q != ST_IDLE);
        o_irq_taken      = 1'b0;
        unique case (state_q)
            ST_TRAP_COMMIT: begin
                o_flush_f_d = 1'b1;
                o_flush_d_e = 1'b1;
                o_flush_e_m = 1'b1;
                o_irq_taken = irq_q;
            end
            ST_TRAP_REDIRECT: begin
                o_flush_f_d      = 1'b1;
                o_flush_d_e      = 1'b1;
                o_flush_e_m      = 1'b1;
                o_redirect_valid = 1'b1;
            end
            ST_MRET_COMMIT: begin
                o_mret      = 1'b1;
                o_flush_f_d = 1'b1;
                o_flush_d_e = 1'b1;
                o_flush_e_m = 1'b1;
            end
            ST_MRET_REDIRECT: o_redirect_valid = 1'b1;
            default: ;
        endcase
    end

    assign o_exception_code_f_d_ff = fd_code_q;
    assign o_exception_pc_f_d_ff   = fd_pc_q;
    assign o_exception_code_e_m_ff = em_code_q;
    assign o_exception_pc_e_m_ff   = em_pc_q;
    assign o_exception_addr_e_m_ff = em_addr_q;

    trap_target_calc u_target (
        .i_mtvec    (i_mtvec),
        .i_mepc     (i_mepc),
        .i_sel_mepc (state_q == ST_MRET_REDIRECT),
        .i_irq      (irq_q),
        .i_valid    (o_redirect_valid),
        .o_pc       (o_redirect_pc)
    );

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer.
// Works with and without TRAP_SEQ_EXT_IRQ_EN.
module tb_trap_sequencer;

    localparam logic [3:0] T_NO_E = 4'hF;
    localparam logic [3:0] T_IRQ  = 4'd11;
    localparam logic [3:0] T_ILL  = 4'd2;

    logic        clk = 1'b0;
    logic        rst, clk_en;
    logic [3:0]  code_fd, code_em;
    logic [31:0] pc_fd, pc_em, addr_em, pc_e;
    logic        mret_e, ext_irq;
    logic [31:0] mtvec, mepc, mie;
    logic [3:0]  fd_code, em_code;
    logic [31:0] fd_pc, em_pc, em_addr, rd_pc;
    logic        mret, fl_fd, fl_de, fl_em, rd_v, busy, irq_tk;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    trap_sequencer dut (
        .i_clk                   (clk),
        .i_rst                   (rst),
        .i_clk_en                (clk_en),
        .i_exc_code_fd           (code_fd),
        .i_exc_pc_fd             (pc_fd),
        .i_exc_code_em           (code_em),
        .i_exc_pc_em             (pc_em),
        .i_exc_addr_em           (addr_em),
        .i_mret_e                (mret_e),
        .i_pc_e                  (pc_e),
`ifdef TRAP_SEQ_EXT_IRQ_EN
        .i_ext_irq               (ext_irq),
`endif
        .i_mtvec                 (mtvec),
        .i_mepc                  (mepc),
        .i_mie                   (mie),
        .o_exception_code_f_d_ff (fd_code),
        .o_exception_pc_f_d_ff   (fd_pc),
        .o_exception_code_e_m_ff (em_code),
        .o_exception_pc_e_m_ff   (em_pc),
        .o_exception_addr_e_m_ff (em_addr),
        .o_mret                  (mret),
        .o_flush_f_d             (fl_fd),
        .o_flush_d_e             (fl_de),
        .o_flush_e_m             (fl_em),
        .o_redirect_valid        (rd_v),
        .o_redirect_pc           (rd_pc),
        .o_busy                  (busy),
        .o_irq_taken             (irq_tk)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        code_fd = T_NO_E;
        code_em = T_NO_E;
        mret_e  = 1'b0;
        ext_irq = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b1;
        clear_events();
        pc_fd = 0; pc_em = 0; addr_em = 0; pc_e = 0;
        mtvec = 32'h80; mepc = 0; mie = 0;
        tick(); tick();
        rst = 1'b0;
        vectors++;
        if ({fd_code, em_code} !== {T_NO_E, T_NO_E}) begin
            miscompares++;
            $display("FAIL reset_codes got %h want %h", {fd_code, em_code}, {T_NO_E, T_NO_E});
        end
        vectors++;
        if ({fd_pc, em_pc, em_addr, rd_pc} !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_data got %h want 0", {fd_pc, em_pc, em_addr, rd_pc});
        end
        vectors++;
        if ({mret, fl_fd, fl_de, fl_em, rd_v, busy, irq_tk} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 0000000", {mret, fl_fd, fl_de, fl_em, rd_v, busy, irq_tk});
        end
    endtask

    task automatic test_em_trap();
        mtvec = 32'h80;
        code_em = T_ILL; pc_em = 32'h100; addr_em = 32'h0DEADBEE;
        tick();
        clear_events();
        vectors++;
        if ({em_code, fd_code} !== {T_ILL, T_NO_E}) begin
            miscompares++;
            $display("FAIL em_commit_codes got %h want %h", {em_code, fd_code}, {T_ILL, T_NO_E});
        end
        vectors++;
        if ({em_pc, em_addr} !== {32'h100, 32'h0DEADBEE}) begin
            miscompares++;
            $display("FAIL em_commit_data got %h want %h", {em_pc, em_addr}, {32'h100, 32'h0DEADBEE});
        end
        vectors++;
        if ({fl_fd, fl_de, fl_em, rd_v, busy, mret, irq_tk} !== 7'b1110100) begin
            miscompares++;
            $display("FAIL em_commit_ctrl got %b want 1110100", {fl_fd, fl_de, fl_em, rd_v, busy, mret, irq_tk});
        end
        tick();
        vectors++;
        if ({rd_v, rd_pc, fl_fd, fl_de, fl_em} !== {1'b1, 32'h80, 3'b111}) begin
            miscompares++;
            $display("FAIL em_redirect got %h want %h", {rd_v, rd_pc, fl_fd, fl_de, fl_em}, {1'b1, 32'h80, 3'b111});
        end
        vectors++;
        if (em_code !== T_NO_E) begin
            miscompares++;
            $display("FAIL em_code_retired got %h want %h", em_code, T_NO_E);
        end
        tick();
        vectors++;
        if ({busy, rd_v, rd_pc, fl_fd} !== 35'h0) begin
            miscompares++;
            $display("FAIL em_idle got %h want 0", {busy, rd_v, rd_pc, fl_fd});
        end
    endtask

    task automatic test_fd_trap();
        mtvec = 32'h81;
        code_fd = 4'd1; pc_fd = 32'h500;
        tick();
        clear_events();
        vectors++;
        if ({fd_code, fd_pc, em_code} !== {4'd1, 32'h500, T_NO_E}) begin
            miscompares++;
            $display("FAIL fd_commit got %h want %h", {fd_code, fd_pc, em_code}, {4'd1, 32'h500, T_NO_E});
        end
        tick();
        vectors++;
        if ({rd_v, rd_pc} !== {1'b1, 32'h80}) begin
            miscompares++;
            $display("FAIL fd_redirect got %h want %h", {rd_v, rd_pc}, {1'b1, 32'h80});
        end
        tick();
    endtask

    task automatic test_simultaneous();
        mtvec = 32'h80;
        code_fd = 4'd1; pc_fd = 32'h200;
        code_em = 4'd5; pc_em = 32'h300; addr_em = 32'h44;
        mret_e = 1'b1;
        tick();
        clear_events();
        vectors++;
        if ({em_code, em_pc, em_addr, fd_code} !== {4'd5, 32'h300, 32'h44, T_NO_E}) begin
            miscompares++;
            $display("FAIL simul_winner got %h want %h", {em_code, em_pc, em_addr, fd_code}, {4'd5, 32'h300, 32'h44, T_NO_E});
        end
        tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_busy2 got %b want 1", busy);
        end
        tick();
        vectors++;
        if ({busy, mret} !== 2'b00) begin
            miscompares++;
            $display("FAIL simul_idle got %b want 00", {busy, mret});
        end
    endtask

    task automatic test_mret();
        mepc = 32'h204;
        mret_e = 1'b1;
        tick();
        clear_events();
        code_em = T_ILL; pc_em = 32'h900; addr_em = 32'h12;
        vectors++;
        if ({mret, fl_fd, fl_de, fl_em, rd_v, busy} !== 6'b111101) begin
            miscompares++;
            $display("FAIL mret_commit got %b want 111101", {mret, fl_fd, fl_de, fl_em, rd_v, busy});
        end
        tick();
        clear_events();
        vectors++;
        if ({mret, rd_v, rd_pc} !== {1'b0, 1'b1, 32'h204}) begin
            miscompares++;
            $display("FAIL mret_redirect got %h want %h", {mret, rd_v, rd_pc}, {1'b0, 1'b1, 32'h204});
        end
        vectors++;
        if ({em_code, fl_em} !== {T_NO_E, 1'b0}) begin
            miscompares++;
            $display("FAIL mret_exc_ignored got %h want %h", {em_code, fl_em}, {T_NO_E, 1'b0});
        end
        tick();
        vectors++;
        if ({busy, rd_v} !== 2'b00) begin
            miscompares++;
            $display("FAIL mret_idle got %b want 00", {busy, rd_v});
        end
    endtask

    task automatic test_irq();
        ext_irq = 1'b1; mie = 32'h0; mtvec = 32'h1001; pc_e = 32'h40;
        tick();
        vectors++;
        if ({busy, irq_tk} !== 2'b00) begin
            miscompares++;
            $display("FAIL irq_masked got %b want 00", {busy, irq_tk});
        end
`ifdef TRAP_SEQ_EXT_IRQ_EN
        mie = 32'h800;
        tick();
        ext_irq = 1'b0;
        vectors++;
        if ({irq_tk, em_code, em_pc, em_addr, fd_code} !== {1'b1, T_IRQ, 32'h40, 32'h0, T_NO_E}) begin
            miscompares++;
            $display("FAIL irq_commit got %h want %h", {irq_tk, em_code, em_pc, em_addr, fd_code}, {1'b1, T_IRQ, 32'h40, 32'h0, T_NO_E});
        end
        tick();
        vectors++;
        if ({irq_tk, rd_v, rd_pc} !== {1'b0, 1'b1, 32'h102C}) begin
            miscompares++;
            $display("FAIL irq_redirect got %h want %h", {irq_tk, rd_v, rd_pc}, {1'b0, 1'b1, 32'h102C});
        end
        tick();
`else
        mie = 32'h800;
        tick();
        vectors++;
        if ({busy, irq_tk, em_code} !== {1'b0, 1'b0, T_NO_E}) begin
            miscompares++;
            $display("FAIL irq_absent got %h want %h", {busy, irq_tk, em_code}, {1'b0, 1'b0, T_NO_E});
        end
`endif
        clear_events();
        mie = 0; mtvec = 32'h80;
        tick();
    endtask

    task automatic test_clk_en();
        code_em = 4'd7; pc_em = 32'h600; addr_em = 32'hABC;
        tick();
        clear_events();
        clk_en = 1'b0;
        code_fd = 4'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({em_code, em_pc, fl_fd, fl_de, fl_em, rd_v, busy} !== {4'd7, 32'h600, 5'b11101}) begin
                miscompares++;
                $display("FAIL clken_hold%0d got %h want %h", i, {em_code, em_pc, fl_fd, fl_de, fl_em, rd_v, busy}, {4'd7, 32'h600, 5'b11101});
            end
        end
        clk_en = 1'b1;
        tick();
        vectors++;
        if ({em_code, rd_v, rd_pc} !== {T_NO_E, 1'b1, 32'h80}) begin
            miscompares++;
            $display("FAIL clken_resume got %h want %h", {em_code, rd_v, rd_pc}, {T_NO_E, 1'b1, 32'h80});
        end
        rst = 1'b1; clk_en = 1'b0;
        tick();
        rst = 1'b0; clk_en = 1'b1;
        clear_events();
        vectors++;
        if ({busy, rd_v, rd_pc, fl_fd, fl_de, fl_em, mret, irq_tk} !== 39'h0) begin
            miscompares++;
            $display("FAIL rst_mid_ctrl got %h want 0", {busy, rd_v, rd_pc, fl_fd, fl_de, fl_em, mret, irq_tk});
        end
        vectors++;
        if ({fd_code, em_code, fd_pc, em_pc, em_addr} !== {T_NO_E, T_NO_E, 96'h0}) begin
            miscompares++;
            $display("FAIL rst_mid_data got %h want %h", {fd_code, em_code, fd_pc, em_pc, em_addr}, {T_NO_E, T_NO_E, 96'h0});
        end
    endtask

    task automatic test_back_to_back();
        code_em = 4'd4; pc_em = 32'h700; addr_em = 32'h8;
        tick();
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle got %b want 0", busy);
        end
        tick();
        clear_events();
        vectors++;
        if ({busy, em_code, em_pc} !== {1'b1, 4'd4, 32'h700}) begin
            miscompares++;
            $display("FAIL b2b_second got %h want %h", {busy, em_code, em_pc}, {1'b1, 4'd4, 32'h700});
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_em_trap();
        test_fd_trap();
        test_simultaneous();
        test_mret();
        test_irq();
        test_clk_en();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
